// File: rtl/hazard_unit_pkg.sv
// Shared types for the decode-stage hazard unit: register-bus width,
// EX-stage result-source codes and MDU sequencer state encodings.
package hazard_unit_pkg;

  localparam int unsigned PREG_W = 6;

  typedef enum logic [1:0] {
    EX_ALU = 2'd0,
    EX_MEM = 2'd1,
    EX_MDU = 2'd2,
    EX_CSR = 2'd3
  } ex_src_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/hazard_unit_mdu_sequencer.sv
// MDU sequencer: IDLE/BUSY/DONE FSM, non-wrapping countdown, in-flight destination
// register and registered busy/done strobes.
module hazard_unit_mdu_sequencer
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [PREG_W-1:0] dest_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [PREG_W-1:0] dest_addr_o
);

  // BUSY spans MDU_LATENCY-1 cycles, so done lands MDU_LATENCY cycles after start.
  localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(MDU_LATENCY - 2);

  mdu_state_e          state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [PREG_W-1:0]    dest_q;
  logic                 busy_q;
  logic                 done_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MDU_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= MDU_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a launch; DONE otherwise falls back to IDLE.
          if (start_i) begin
            state_q <= MDU_BUSY;
            cnt_q   <= RELOAD;
            dest_q  <= dest_i;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= MDU_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dest_addr_o = dest_q;

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage interlock: load-use and MDU RAW/WAW/structural stalls plus MDU launch.
// Define HAZARD_PERF_EN to add the saturating stall_cycles counter port.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_WIDTH   = 6,
  parameter int unsigned PERF_WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic              dec_rs_enable,
  input  logic [PREG_W-1:0] dec_prs_addr,
  input  logic              dec_rt_enable,
  input  logic [PREG_W-1:0] dec_prt_addr,
  input  logic              dec_wb_reg,
  input  logic [PREG_W-1:0] dec_write_addr,
  input  logic              dec_is_mdu,
  input  logic              exec_wb_reg,
  input  logic [1:0]        exec_exec_src,
  input  logic [PREG_W-1:0] exec_write_addr,
  output logic              stall_fetch,
  output logic              stall_dec,
  output logic              bubble_exec,
  output logic              mdu_start,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [PREG_W-1:0] mdu_dest_addr
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] stall_cycles
`endif
);

  logic load_use;
  logic mdu_hazard;
  logic stall;

  // A load result is only forwardable from MEM onward, so EX-stage loads must stall.
  assign load_use = exec_wb_reg && (exec_exec_src == EX_MEM) &&
                    ((dec_rs_enable && (dec_prs_addr == exec_write_addr)) ||
                     (dec_rt_enable && (dec_prt_addr == exec_write_addr)));

  // Only BUSY interlocks; in DONE the result is on the bypass network.
  assign mdu_hazard = mdu_busy &&
                      (dec_is_mdu ||
                       (dec_wb_reg    && (dec_write_addr == mdu_dest_addr)) ||
                       (dec_rs_enable && (dec_prs_addr   == mdu_dest_addr)) ||
                       (dec_rt_enable && (dec_prt_addr   == mdu_dest_addr)));

  assign stall       = dec_valid && !flush && (load_use || mdu_hazard);
  assign stall_fetch = stall;
  assign stall_dec   = stall;
  assign bubble_exec = stall;

  assign mdu_start = dec_valid && dec_is_mdu && !stall && !flush && !mdu_busy;

  hazard_unit_mdu_sequencer #(
    .MDU_LATENCY(MDU_LATENCY),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_mdu_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (mdu_start),
    .dest_i     (dec_write_addr),
    .busy_o     (mdu_busy),
    .done_o     (mdu_done),
    .dest_addr_o(mdu_dest_addr)
  );

`ifdef HAZARD_PERF_EN
  logic [PERF_WIDTH-1:0] stall_cnt_q;
  logic [PERF_WIDTH-1:0] stall_cnt_d;

  // NOTE: the default assignment first keeps this always_comb from inferring a latch.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + PERF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: combinational vector table under reset, then
// hand-written sequences for MDU timing, back-to-back, flush and async reset.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush;
  logic              dec_valid;
  logic              dec_rs_enable;
  logic [PREG_W-1:0] dec_prs_addr;
  logic              dec_rt_enable;
  logic [PREG_W-1:0] dec_prt_addr;
  logic              dec_wb_reg;
  logic [PREG_W-1:0] dec_write_addr;
  logic              dec_is_mdu;
  logic              exec_wb_reg;
  logic [1:0]        exec_exec_src;
  logic [PREG_W-1:0] exec_write_addr;
  logic              stall_fetch;
  logic              stall_dec;
  logic              bubble_exec;
  logic              mdu_start;
  logic              mdu_busy;
  logic              mdu_done;
  logic [PREG_W-1:0] mdu_dest_addr;
`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .dec_valid      (dec_valid),
    .dec_rs_enable  (dec_rs_enable),
    .dec_prs_addr   (dec_prs_addr),
    .dec_rt_enable  (dec_rt_enable),
    .dec_prt_addr   (dec_prt_addr),
    .dec_wb_reg     (dec_wb_reg),
    .dec_write_addr (dec_write_addr),
    .dec_is_mdu     (dec_is_mdu),
    .exec_wb_reg    (exec_wb_reg),
    .exec_exec_src  (exec_exec_src),
    .exec_write_addr(exec_write_addr),
    .stall_fetch    (stall_fetch),
    .stall_dec      (stall_dec),
    .bubble_exec    (bubble_exec),
    .mdu_start      (mdu_start),
    .mdu_busy       (mdu_busy),
    .mdu_done       (mdu_done),
    .mdu_dest_addr  (mdu_dest_addr)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  typedef struct packed {
    logic              flush;
    logic              valid;
    logic              rs_en;
    logic [PREG_W-1:0] prs;
    logic              rt_en;
    logic [PREG_W-1:0] prt;
    logic              wb;
    logic [PREG_W-1:0] waddr;
    logic              is_mdu;
    logic              ex_wb;
    logic [1:0]        ex_src;
    logic [PREG_W-1:0] ex_waddr;
    logic              exp_stall;
    logic              exp_start;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] stalls();
    return {stall_fetch, stall_dec, bubble_exec};
  endfunction

  task automatic set_idle();
    flush           = 1'b0;
    dec_valid       = 1'b0;
    dec_rs_enable   = 1'b0;
    dec_prs_addr    = '0;
    dec_rt_enable   = 1'b0;
    dec_prt_addr    = '0;
    dec_wb_reg      = 1'b0;
    dec_write_addr  = '0;
    dec_is_mdu      = 1'b0;
    exec_wb_reg     = 1'b0;
    exec_exec_src   = EX_ALU;
    exec_write_addr = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    flush           = v.flush;
    dec_valid       = v.valid;
    dec_rs_enable   = v.rs_en;
    dec_prs_addr    = v.prs;
    dec_rt_enable   = v.rt_en;
    dec_prt_addr    = v.prt;
    dec_wb_reg      = v.wb;
    dec_write_addr  = v.waddr;
    dec_is_mdu      = v.is_mdu;
    exec_wb_reg     = v.ex_wb;
    exec_exec_src   = v.ex_src;
    exec_write_addr = v.ex_waddr;
  endtask

  task automatic drive_mdu(input logic [PREG_W-1:0] dest);
    set_idle();
    dec_valid      = 1'b1;
    dec_is_mdu     = 1'b1;
    dec_wb_reg     = 1'b1;
    dec_write_addr = dest;
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // From cycle t_now (relative to the start cycle t0), stop at the t32 negedge.
  task automatic run_to_done(input int t_now, input string tag);
    for (int t = t_now; t <= 32; t++) begin
      @(negedge clk);
      if (t == 31) check({tag, " no early done"}, mdu_done, 1'b0);
      if (t == 32) check({tag, " done"}, mdu_done, 1'b1);
      if (t < 32) cyc();
    end
  endtask

  initial begin
    //          flush valid rs  prs    rt  prt    wb  waddr  mdu exwb src     exwaddr stall start
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, EX_ALU, 6'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 6'd7, 1'b0, 1'b1, EX_MEM, 6'd5, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 6'd7, 1'b0, 1'b1, EX_ALU, 6'd5, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 6'd5, 1'b0, 6'd0, 1'b1, 6'd7, 1'b0, 1'b1, EX_MEM, 6'd5, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 6'd1, 1'b1, 6'd5, 1'b1, 6'd7, 1'b0, 1'b1, EX_MEM, 6'd5, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 6'd7, 1'b0, 1'b0, EX_MEM, 6'd5, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 6'd6, 1'b1, 6'd4, 1'b1, 6'd7, 1'b0, 1'b1, EX_MEM, 6'd5, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 6'd7, 1'b0, 1'b1, EX_MEM, 6'd5, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 6'd7, 1'b1, 1'b1, EX_MEM, 6'd5, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd9, 1'b1, 1'b0, EX_ALU, 6'd0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 6'd9, 1'b1, 1'b1, EX_MEM, 6'd5, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd9, 1'b1, 1'b0, EX_ALU, 6'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0, 1'b0, 1'b0, EX_ALU, 6'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd9, 1'b1, 1'b0, EX_ALU, 6'd0, 1'b0, 1'b0};

    // Reset state and combinational vectors, all with rst_n held low so no MDU op launches.
    set_idle();
    #1;
    check("reset busy", mdu_busy, 1'b0);
    check("reset done", mdu_done, 1'b0);
    check("reset dest", mdu_dest_addr, '0);
    check("reset stalls", stalls(), 3'b000);
    check("reset start", mdu_start, 1'b0);
    for (int i = 0; i < NVEC; i++) begin
      apply_vec(vecs[i]);
      #1;
      check($sformatf("vec[%0d] stalls", i), stalls(), {3{vecs[i].exp_stall}});
      check($sformatf("vec[%0d] start", i), mdu_start, vecs[i].exp_start);
      check($sformatf("vec[%0d] busy", i), mdu_busy, 1'b0);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
`ifdef HAZARD_PERF_EN
    check("perf after reset", stall_cycles, 32'd0);
`endif
    cyc();

    // MDU RAW: mult -> p9 at t0, dependent reader from t1.
    drive_mdu(6'd9);
    @(negedge clk);
    check("raw start", mdu_start, 1'b1);
    check("raw start no stall", stalls(), 3'b000);
    cyc();
    set_idle();
    dec_valid      = 1'b1;
    dec_rs_enable  = 1'b1;
    dec_prs_addr   = 6'd9;
    dec_wb_reg     = 1'b1;
    dec_write_addr = 6'd11;
    for (int t = 1; t <= 33; t++) begin
      @(negedge clk);
      if (t == 1) check("raw dest", mdu_dest_addr, 6'd9);
      check($sformatf("raw stall t%0d", t), stalls(), (t <= 31) ? 3'b111 : 3'b000);
      check($sformatf("raw busy t%0d", t), mdu_busy, (t <= 31) ? 1'b1 : 1'b0);
      check($sformatf("raw done t%0d", t), mdu_done, (t == 32) ? 1'b1 : 1'b0);
      cyc();
    end
`ifdef HAZARD_PERF_EN
    check("perf after raw", stall_cycles, 32'd31);
`endif

    // Load-use: one stall cycle, then EX holds the bubble and the stall clears.
    set_idle();
    dec_valid       = 1'b1;
    dec_rs_enable   = 1'b1;
    dec_prs_addr    = 6'd5;
    exec_wb_reg     = 1'b1;
    exec_exec_src   = EX_MEM;
    exec_write_addr = 6'd5;
    @(negedge clk);
    check("lu stall", stalls(), 3'b111);
    cyc();
    exec_wb_reg = 1'b0;
    @(negedge clk);
    check("lu released", stalls(), 3'b000);
    cyc();

    // Structural / WAW / RAW-on-rt during BUSY.
    drive_mdu(6'd12);
    @(negedge clk);
    check("s3 start", mdu_start, 1'b1);
    cyc();
    drive_mdu(6'd13);
    @(negedge clk);
    check("s3 structural stall", stalls(), 3'b111);
    check("s3 structural no start", mdu_start, 1'b0);
    cyc();
    set_idle();
    dec_valid      = 1'b1;
    dec_wb_reg     = 1'b1;
    dec_write_addr = 6'd12;
    @(negedge clk);
    check("s3 waw stall", stalls(), 3'b111);
    cyc();
    dec_write_addr = 6'd10;
    dec_rs_enable  = 1'b1;
    dec_prs_addr   = 6'd3;
    @(negedge clk);
    check("s3 p10 no stall", stalls(), 3'b000);
    cyc();
    dec_rt_enable = 1'b1;
    dec_prt_addr  = 6'd12;
    @(negedge clk);
    check("s3 raw rt stall", stalls(), 3'b111);
    cyc();
    set_idle();
    run_to_done(5, "s3");
    cyc();

    // Back-to-back: second op launched in the DONE cycle.
    drive_mdu(6'd20);
    @(negedge clk);
    check("b2b first start", mdu_start, 1'b1);
    cyc();
    set_idle();
    run_to_done(1, "b2b first");
    drive_mdu(6'd21);
    #1;
    check("b2b second start", mdu_start, 1'b1);
    check("b2b no stall in done", stalls(), 3'b000);
    cyc();
    set_idle();
    @(negedge clk);
    check("b2b busy again", mdu_busy, 1'b1);
    check("b2b dest", mdu_dest_addr, 6'd21);
    cyc();
    run_to_done(2, "b2b second");
    cyc();
    set_idle();
    @(negedge clk);
    check("b2b idle after", mdu_busy | mdu_done, 1'b0);
    cyc();

    // Flush masks stalls and start but not the in-flight op.
    drive_mdu(6'd7);
    @(negedge clk);
    check("fl start", mdu_start, 1'b1);
    cyc();
    for (int t = 1; t <= 4; t++) begin
      drive_mdu(6'd7);
      flush           = 1'b1;
      dec_rs_enable   = 1'b1;
      dec_prs_addr    = 6'd5;
      exec_wb_reg     = 1'b1;
      exec_exec_src   = EX_MEM;
      exec_write_addr = 6'd5;
      @(negedge clk);
      check($sformatf("fl stalls t%0d", t), stalls(), 3'b000);
      check($sformatf("fl start t%0d", t), mdu_start, 1'b0);
      check($sformatf("fl busy t%0d", t), mdu_busy, 1'b1);
      cyc();
    end
    set_idle();
    run_to_done(5, "fl");
    cyc();

    // Async reset at BUSY count 10 (cycle t21 after start).
    drive_mdu(6'd8);
    cyc();
    set_idle();
    for (int t = 1; t < 21; t++) cyc();
    #2;
    check("rst mid busy before", mdu_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst busy", mdu_busy, 1'b0);
    check("rst done", mdu_done, 1'b0);
    check("rst dest", mdu_dest_addr, '0);
`ifdef HAZARD_PERF_EN
    check("rst perf", stall_cycles, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic done_seen;
      done_seen = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        done_seen = done_seen | mdu_done;
      end
      check("rst no lost done", done_seen, 1'b0);
      check("rst stays idle", mdu_busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
